// File: rtl/os_cache_sequencer.sv
// os_cache_sequencer: drives the w/a/psum cache command port for one
// output-stationary tile (clear, load W, load A, stream pairs, drain psums).
module os_cache_sequencer #(
  parameter int wa_bits     = 8,
  parameter int addr_bits   = 8,
  parameter int p_addr_bits = 5
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_start,
  input  logic                   w_cfg_clear,
  input  logic [addr_bits-1:0]   w_cfg_nw_m1,
  input  logic [addr_bits-1:0]   w_cfg_na_m1,
  input  logic [15:0]            w_cfg_ns_m1,
  input  logic [p_addr_bits-1:0] w_cfg_np_m1,
  input  logic                   w_bus_valid,
  input  logic [wa_bits-1:0]     w_bus_data,
  input  logic                   w_pe_ready,
  input  logic                   w_out_ready,
  output logic                   r_bus_ready,
  output logic                   r_cache_ready,
  output logic [2:0]             r_cache_state,
  output logic [addr_bits-1:0]   r_cache_w_addr,
  output logic [addr_bits-1:0]   r_cache_a_addr,
  output logic [wa_bits-1:0]     r_cache_bus,
  output logic                   r_pe_valid,
  output logic                   r_psum_valid,
  output logic                   r_busy,
  output logic                   r_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_LOAD_A = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] C_LOAD_W = 3'b000;
  localparam logic [2:0] C_LOAD_A = 3'b001;
  localparam logic [2:0] C_STREAM = 3'b100;
  localparam logic [2:0] C_DRAIN  = 3'b110;
  localparam logic [2:0] C_IDLE   = 3'b111;

  logic [2:0]             st_q, st_d;
  logic [addr_bits-1:0]   nw_q, nw_d, na_q, na_d;
  logic [15:0]            ns_q, ns_d;
  logic [p_addr_bits-1:0] np_q, np_d;
  logic [addr_bits-1:0]   cnt_q, cnt_d;
  logic [addr_bits-1:0]   wi_q, wi_d, ai_q, ai_d;
  logic [15:0]            beat_q, beat_d;
  logic [p_addr_bits-1:0] pi_q, pi_d;
  logic                   bus_rdy_q, bus_rdy_d;
  logic                   rdy_q, rdy_d;
  logic [2:0]             cst_q, cst_d;
  logic [addr_bits-1:0]   wa_q, wa_d, aa_q, aa_d;
  logic [wa_bits-1:0]     bus_q, bus_d;
  logic                   pev_q, pev_d, psv_q, psv_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   accept;

  assign accept = w_bus_valid & bus_rdy_q;

  always_comb begin
    st_d      = st_q;
    nw_d      = nw_q;
    na_d      = na_q;
    ns_d      = ns_q;
    np_d      = np_q;
    cnt_d     = cnt_q;
    wi_d      = wi_q;
    ai_d      = ai_q;
    beat_d    = beat_q;
    pi_d      = pi_q;
    bus_rdy_d = bus_rdy_q;
    rdy_d     = rdy_q;
    cst_d     = C_IDLE;
    wa_d      = wa_q;
    aa_d      = aa_q;
    bus_d     = bus_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    // cache read latency is one cycle after the command is presented
    pev_d     = (cst_q == C_STREAM);
    psv_d     = (cst_q == C_DRAIN);
    case (st_q)
      S_IDLE: begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        if (w_start) begin
          nw_d   = w_cfg_nw_m1;
          na_d   = w_cfg_na_m1;
          ns_d   = w_cfg_ns_m1;
          np_d   = w_cfg_np_m1;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (w_cfg_clear) begin
            st_d  = S_CLEAR;
            rdy_d = 1'b0;
          end else begin
            st_d      = S_LOAD_W;
            bus_rdy_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        rdy_d     = 1'b1;
        bus_rdy_d = 1'b1;
        st_d      = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (accept) begin
          cst_d = C_LOAD_W;
          wa_d  = cnt_q;
          bus_d = w_bus_data;
          if (cnt_q == nw_q) begin
            cnt_d = '0;
            st_d  = S_LOAD_A;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          cst_d = C_LOAD_A;
          aa_d  = cnt_q;
          bus_d = w_bus_data;
          if (cnt_q == na_q) begin
            cnt_d     = '0;
            wi_d      = '0;
            ai_d      = '0;
            beat_d    = '0;
            bus_rdy_d = 1'b0;
            st_d      = S_STREAM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (w_pe_ready) begin
          cst_d = C_STREAM;
          wa_d  = wi_q;
          aa_d  = ai_q;
          wi_d  = (wi_q == nw_q) ? '0 : wi_q + 1'b1;
          ai_d  = (ai_q == na_q) ? '0 : ai_q + 1'b1;
          if (beat_q == ns_q) begin
            pi_d = '0;
            st_d = S_DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_out_ready) begin
          cst_d = C_DRAIN;
          wa_d  = addr_bits'(pi_q);
          if (pi_q == np_q) begin
            st_d = S_DONE;
          end else begin
            pi_d = pi_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      st_q      <= S_IDLE;
      nw_q      <= '0;
      na_q      <= '0;
      ns_q      <= '0;
      np_q      <= '0;
      cnt_q     <= '0;
      wi_q      <= '0;
      ai_q      <= '0;
      beat_q    <= '0;
      pi_q      <= '0;
      bus_rdy_q <= 1'b0;
      rdy_q     <= 1'b0;
      cst_q     <= C_IDLE;
      wa_q      <= '0;
      aa_q      <= '0;
      bus_q     <= '0;
      pev_q     <= 1'b0;
      psv_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      nw_q      <= nw_d;
      na_q      <= na_d;
      ns_q      <= ns_d;
      np_q      <= np_d;
      cnt_q     <= cnt_d;
      wi_q      <= wi_d;
      ai_q      <= ai_d;
      beat_q    <= beat_d;
      pi_q      <= pi_d;
      bus_rdy_q <= bus_rdy_d;
      rdy_q     <= rdy_d;
      cst_q     <= cst_d;
      wa_q      <= wa_d;
      aa_q      <= aa_d;
      bus_q     <= bus_d;
      pev_q     <= pev_d;
      psv_q     <= psv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign r_bus_ready    = bus_rdy_q;
  assign r_cache_ready  = rdy_q;
  assign r_cache_state  = cst_q;
  assign r_cache_w_addr = wa_q;
  assign r_cache_a_addr = aa_q;
  assign r_cache_bus    = bus_q;
  assign r_pe_valid     = pev_q;
  assign r_psum_valid   = psv_q;
  assign r_busy         = busy_q;
  assign r_done         = done_q;

endmodule

// File: tb/tb_os_cache_sequencer.sv
// tb_os_cache_sequencer: directed scenario bench for the tile
// sequencer; a negedge monitor logs every non-idle cache command.
module tb_os_cache_sequencer;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b0;
  logic       w_start = 1'b0;
  logic       w_cfg_clear = 1'b0;
  logic [7:0] w_cfg_nw_m1 = '0;
  logic [7:0] w_cfg_na_m1 = '0;
  logic [15:0] w_cfg_ns_m1 = '0;
  logic [4:0] w_cfg_np_m1 = '0;
  logic       w_bus_valid = 1'b0;
  logic [7:0] w_bus_data = '0;
  logic       w_pe_ready = 1'b1;
  logic       w_out_ready = 1'b1;
  logic       r_bus_ready, r_cache_ready;
  logic [2:0] r_cache_state;
  logic [7:0] r_cache_w_addr, r_cache_a_addr, r_cache_bus;
  logic       r_pe_valid, r_psum_valid, r_busy, r_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n100, n110, n_pe, n_ps, n_done, n_rlow;
  int done_cyc, last_ps_cyc;
  bit busy_at_done;
  int acc_n = 0;
  bit bus_toggle = 0;
  bit stall_arm = 0;
  int stall_cnt = 0;

  logic [2:0] q_st[$];
  logic [7:0] q_w[$];
  logic [7:0] q_a[$];
  logic [7:0] q_d[$];
  int         q_c[$];
  int         q_pe[$];

  localparam logic [32:0] RST_OUTS = 33'h070000000;

  os_cache_sequencer dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_start(w_start),
    .w_cfg_clear(w_cfg_clear), .w_cfg_nw_m1(w_cfg_nw_m1),
    .w_cfg_na_m1(w_cfg_na_m1), .w_cfg_ns_m1(w_cfg_ns_m1),
    .w_cfg_np_m1(w_cfg_np_m1), .w_bus_valid(w_bus_valid),
    .w_bus_data(w_bus_data), .w_pe_ready(w_pe_ready),
    .w_out_ready(w_out_ready), .r_bus_ready(r_bus_ready),
    .r_cache_ready(r_cache_ready), .r_cache_state(r_cache_state),
    .r_cache_w_addr(r_cache_w_addr), .r_cache_a_addr(r_cache_a_addr),
    .r_cache_bus(r_cache_bus), .r_pe_valid(r_pe_valid),
    .r_psum_valid(r_psum_valid), .r_busy(r_busy), .r_done(r_done)
  );

  initial forever #5 w_clk = ~w_clk;

  // monitor
  initial forever begin
    @(negedge w_clk);
    cyc++;
    if (r_cache_state !== 3'b111) begin
      q_st.push_back(r_cache_state);
      q_w.push_back(r_cache_w_addr);
      q_a.push_back(r_cache_a_addr);
      q_d.push_back(r_cache_bus);
      q_c.push_back(cyc);
    end
    if (r_cache_state === 3'b100) n100++;
    if (r_cache_state === 3'b110) n110++;
    if (r_pe_valid === 1'b1) begin n_pe++; q_pe.push_back(cyc); end
    if (r_psum_valid === 1'b1) begin n_ps++; last_ps_cyc = cyc; end
    if (r_done === 1'b1) begin
      n_done++; done_cyc = cyc; busy_at_done = r_busy;
    end
    if (r_busy === 1'b1 && r_cache_ready === 1'b0) n_rlow++;
  end

  // bus source and PE backpressure driver
  initial begin
    bit acc;
    forever begin
      @(negedge w_clk);
      acc = w_bus_valid && r_bus_ready;
      @(posedge w_clk);
      #1;
      if (acc) acc_n++;
      w_bus_valid = bus_toggle ? !w_bus_valid : 1'b1;
      w_bus_data = 8'(8'h40 + acc_n);
      if (stall_cnt > 0) begin
        w_pe_ready = 1'b0; stall_cnt--;
      end else if (stall_arm && n100 >= 2) begin
        stall_arm = 0; w_pe_ready = 1'b0; stall_cnt = 2;
      end else begin
        w_pe_ready = 1'b1;
      end
    end
  end

  function automatic logic [32:0] outs();
    return {r_bus_ready, r_cache_ready, r_cache_state, r_cache_w_addr,
            r_cache_a_addr, r_cache_bus, r_pe_valid, r_psum_valid,
            r_busy, r_done};
  endfunction

  task automatic clear_log();
    q_st.delete(); q_w.delete(); q_a.delete();
    q_d.delete(); q_c.delete(); q_pe.delete();
    n100 = 0; n110 = 0; n_pe = 0; n_ps = 0; n_done = 0; n_rlow = 0;
    done_cyc = -1; last_ps_cyc = -2; busy_at_done = 0;
  endtask

  task automatic start_tile(input bit clr, input logic [7:0] nw,
                            input logic [7:0] na, input logic [15:0] ns,
                            input logic [4:0] np);
    @(posedge w_clk); #1;
    acc_n = 0;
    w_cfg_clear = clr; w_cfg_nw_m1 = nw; w_cfg_na_m1 = na;
    w_cfg_ns_m1 = ns; w_cfg_np_m1 = np;
    w_start = 1'b1;
    @(posedge w_clk); #1;
    w_start = 1'b0;
    w_cfg_clear = ~clr; w_cfg_nw_m1 = 8'hAA; w_cfg_na_m1 = 8'h55;
    w_cfg_ns_m1 = 16'h1234; w_cfg_np_m1 = 5'h1F;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge w_clk); #1; k++;
    end
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL %s_timeout: no r_done within %0d cycles, want 1 pulse",
               nm, budget);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget,
                            input string nm);
    int k = 0;
    int n = 0;
    while (n == 0 && k < budget) begin
      @(negedge w_clk); #1; k++;
      n = (st == 3'b100) ? n100 : n110;
      if (st == 3'b100 && n < 2) n = 0;
    end
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL %s_timeout: state %b not reached in %0d cycles",
               nm, st, budget);
    end
  endtask

  task automatic test_reset();
    w_rst = 1'b1;
    @(negedge w_clk); #1;
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL reset_outs: got %h want %h", outs(), RST_OUTS);
    end
    w_rst = 1'b0;
    #1;
    checks++;
    if (r_cache_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 0", r_cache_ready);
    end
    @(negedge w_clk); #1;
    checks++;
    if ({r_cache_ready, r_busy, r_cache_state, r_bus_ready} !== 6'b10_111_0) begin
      errors++;
      $display("FAIL idle_outs: rdy/busy/state/busrdy got %b want 101110",
               {r_cache_ready, r_busy, r_cache_state, r_bus_ready});
    end
  endtask

  task automatic test_basic();
    logic [2:0] e_st[$];
    logic [7:0] e_w[$], e_a[$], e_d[$];
    int c100[$];
    bit ok;
    clear_log();
    start_tile(1'b1, 8'd3, 8'd1, 16'd5, 5'd1);
    wait_done(200, "basic");
    @(negedge w_clk); #1;
    for (int k = 0; k < 4; k++) begin
      e_st.push_back(3'b000); e_w.push_back(8'(k));
      e_a.push_back(8'h0); e_d.push_back(8'(8'h40 + k));
    end
    for (int k = 0; k < 2; k++) begin
      e_st.push_back(3'b001); e_w.push_back(8'h0);
      e_a.push_back(8'(k)); e_d.push_back(8'(8'h44 + k));
    end
    for (int b = 0; b < 6; b++) begin
      e_st.push_back(3'b100); e_w.push_back(8'(b % 4));
      e_a.push_back(8'(b % 2)); e_d.push_back(8'h0);
    end
    for (int p = 0; p < 2; p++) begin
      e_st.push_back(3'b110); e_w.push_back(8'(p));
      e_a.push_back(8'h0); e_d.push_back(8'h0);
    end
    checks++;
    if (q_st.size() != e_st.size()) begin
      errors++;
      $display("FAIL basic_cmd_count: got %0d want %0d",
               q_st.size(), e_st.size());
    end
    for (int i = 0; i < e_st.size() && i < q_st.size(); i++) begin
      ok = (q_st[i] === e_st[i]);
      if (e_st[i] != 3'b001) ok = ok && (q_w[i] === e_w[i]);
      if (e_st[i] == 3'b001 || e_st[i] == 3'b100)
        ok = ok && (q_a[i] === e_a[i]);
      if (e_st[i] == 3'b000 || e_st[i] == 3'b001)
        ok = ok && (q_d[i] === e_d[i]);
      if (e_st[i] == 3'b100) c100.push_back(q_c[i]);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL basic_cmd%0d: got st=%b w=%h a=%h d=%h want st=%b w=%h a=%h d=%h",
                 i, q_st[i], q_w[i], q_a[i], q_d[i],
                 e_st[i], e_w[i], e_a[i], e_d[i]);
      end
    end
    checks++;
    if (n_rlow != 1) begin
      errors++;
      $display("FAIL basic_clear_cycles: got %0d want 1", n_rlow);
    end
    checks++;
    if (n_pe != 6 || n_ps != 2 || n_done != 1) begin
      errors++;
      $display("FAIL basic_valid_counts: pe=%0d ps=%0d done=%0d want 6 2 1",
               n_pe, n_ps, n_done);
    end
    for (int i = 0; i < c100.size() && i < q_pe.size(); i++) begin
      checks++;
      if (q_pe[i] != c100[i] + 1) begin
        errors++;
        $display("FAIL basic_pe_latency%0d: valid at %0d want %0d",
                 i, q_pe[i], c100[i] + 1);
      end
    end
    checks++;
    if (done_cyc != last_ps_cyc || !busy_at_done || r_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done@%0d psum@%0d busy@done=%0b busy=%b want equal,1,0",
               done_cyc, last_ps_cyc, busy_at_done, r_busy);
    end
  endtask

  task automatic test_bus_toggle();
    int n = 0;
    int prev = 0;
    clear_log();
    bus_toggle = 1;
    start_tile(1'b0, 8'd3, 8'd1, 16'd1, 5'd0);
    wait_done(200, "toggle");
    bus_toggle = 0;
    for (int i = 0; i < q_st.size(); i++) begin
      if (q_st[i] == 3'b000) begin
        checks++;
        if (q_w[i] !== 8'(n) || q_d[i] !== 8'(8'h40 + n) ||
            (n > 0 && q_c[i] - prev != 2)) begin
          errors++;
          $display("FAIL toggle_load%0d: w=%h d=%h gap=%0d want w=%h d=%h gap=2",
                   n, q_w[i], q_d[i], q_c[i] - prev, 8'(n), 8'(8'h40 + n));
        end
        prev = q_c[i];
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL toggle_load_count: got %0d want 4", n);
    end
  endtask

  task automatic test_pe_stall();
    int b = 0;
    int first = 0;
    int last = 0;
    clear_log();
    stall_arm = 1;
    start_tile(1'b0, 8'd3, 8'd1, 16'd5, 5'd1);
    wait_done(200, "stall");
    for (int i = 0; i < q_st.size(); i++) begin
      if (q_st[i] == 3'b100) begin
        if (b == 0) first = q_c[i];
        last = q_c[i];
        checks++;
        if (q_w[i] !== 8'(b % 4) || q_a[i] !== 8'(b % 2)) begin
          errors++;
          $display("FAIL stall_beat%0d: w=%h a=%h want %h %h",
                   b, q_w[i], q_a[i], 8'(b % 4), 8'(b % 2));
        end
        b++;
      end
    end
    checks++;
    if (b != 6 || n_pe != 6 || last - first != 8) begin
      errors++;
      $display("FAIL stall_shape: beats=%0d pe=%0d span=%0d want 6 6 8",
               b, n_pe, last - first);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] sw[$];
    int bad = 0;
    int nl = 0;
    logic [7:0] lastw = 8'h0;
    clear_log();
    start_tile(1'b0, 8'd255, 8'd0, 16'd511, 5'd0);
    wait_done(2000, "wrap");
    for (int i = 0; i < q_st.size(); i++) begin
      if (q_st[i] == 3'b000) begin nl++; lastw = q_w[i]; end
      if (q_st[i] == 3'b100) begin
        if (q_a[i] !== 8'h0 || q_w[i] !== 8'(sw.size() % 256)) bad++;
        sw.push_back(q_w[i]);
      end
    end
    checks++;
    if (nl != 256 || lastw !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_loads: n=%0d last=%h want 256 ff", nl, lastw);
    end
    checks++;
    if (sw.size() != 512) begin
      errors++;
      $display("FAIL wrap_beats: got %0d want 512", sw.size());
    end else begin
      checks++;
      if (sw[255] !== 8'hFF || sw[256] !== 8'h00 || sw[511] !== 8'hFF) begin
        errors++;
        $display("FAIL wrap_points: w255=%h w256=%h w511=%h want ff 00 ff",
                 sw[255], sw[256], sw[511]);
      end
    end
    checks++;
    if (bad != 0 || n_ps != 1) begin
      errors++;
      $display("FAIL wrap_seq: bad=%0d psums=%0d want 0 1", bad, n_ps);
    end
  endtask

  task automatic test_start_ignored();
    int b = 0;
    clear_log();
    start_tile(1'b0, 8'd3, 8'd1, 16'd5, 5'd1);
    wait_state(3'b100, 200, "ignore");
    start_tile(1'b1, 8'd7, 8'd7, 16'd20, 5'd9);
    wait_done(200, "ignore");
    repeat (5) @(negedge w_clk);
    #1;
    for (int i = 0; i < q_st.size(); i++) begin
      if (q_st[i] == 3'b100) begin
        checks++;
        if (q_w[i] !== 8'(b % 4) || q_a[i] !== 8'(b % 2)) begin
          errors++;
          $display("FAIL ignore_beat%0d: w=%h a=%h want %h %h",
                   b, q_w[i], q_a[i], 8'(b % 4), 8'(b % 2));
        end
        b++;
      end
    end
    checks++;
    if (b != 6 || n110 != 2 || n_done != 1 || n_rlow != 0 || r_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_tile: beats=%0d drains=%0d done=%0d clr=%0d busy=%b want 6 2 1 0 0",
               b, n110, n_done, n_rlow, r_busy);
    end
  endtask

  task automatic test_reset_drain();
    clear_log();
    start_tile(1'b0, 8'd3, 8'd1, 16'd5, 5'd1);
    wait_state(3'b110, 200, "rstdrain");
    #1;
    w_rst = 1'b1;
    #1;
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL rstdrain_async: got %h want %h", outs(), RST_OUTS);
    end
    @(negedge w_clk); #1;
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++;
      $display("FAIL rstdrain_hold: got %h want %h", outs(), RST_OUTS);
    end
    w_rst = 1'b0;
    @(negedge w_clk); #1;
    checks++;
    if (r_cache_ready !== 1'b1 || r_busy !== 1'b0 || n_done != 0) begin
      errors++;
      $display("FAIL rstdrain_release: rdy=%b busy=%b done=%0d want 1 0 0",
               r_cache_ready, r_busy, n_done);
    end
    clear_log();
    start_tile(1'b1, 8'd3, 8'd1, 16'd5, 5'd1);
    wait_done(200, "rstdrain_rerun");
    @(negedge w_clk); #1;
    checks++;
    if (q_st.size() != 14 || n_rlow != 1 || n110 != 2 || n_done != 1) begin
      errors++;
      $display("FAIL rstdrain_rerun: cmds=%0d clr=%0d drains=%0d done=%0d want 14 1 2 1",
               q_st.size(), n_rlow, n110, n_done);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_bus_toggle();
    test_pe_stall();
    test_wrap();
    test_start_ignored();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/os_cache_sequencer.md
Name: os_cache_sequencer

Overview:
Sequences one output-stationary tile through the weight/activation/psum cache. It loads N weights then M activations from the bus, streams S weight/activation pairs (cache state 100) to the PE array with backpressure, then drains P psums (cache state 110). It drives the cache's clock-domain command port (ready, state, addresses, registered bus data) and reports busy/done to the tile controller.

Parameters:
wa_bits, 8, width of weight/activation words
addr_bits, 8, width of cache addresses (256-entry w/a arrays)
p_addr_bits, 5, psum index width (32 psum rows)

Ports:
w_clk  in  1  clock
w_rst  in  1  asynchronous active-high reset
w_start  in  1  start pulse; sampled only in IDLE
w_cfg_clear  in  1  clear cache before tile
w_cfg_nw_m1  in  addr_bits  weights to load minus 1
w_cfg_na_m1  in  addr_bits  activations to load minus 1
w_cfg_ns_m1  in  16  stream beats minus 1
w_cfg_np_m1  in  p_addr_bits  psums to drain minus 1
w_bus_valid  in  1  upstream word valid
w_bus_data  in  wa_bits  upstream word
w_pe_ready  in  1  PE array accepts a w/a pair
w_out_ready  in  1  downstream accepts a psum
r_bus_ready  out  1  accept upstream word this cycle
r_cache_ready  out  1  to cache ready (low = clear)
r_cache_state  out  3  to cache state
r_cache_w_addr  out  addr_bits  to cache weight/psum address
r_cache_a_addr  out  addr_bits  to cache activation address
r_cache_bus  out  wa_bits  registered bus word to cache bus input
r_pe_valid  out  1  cache w/a outputs valid this cycle
r_psum_valid  out  1  cache psum output valid this cycle
r_busy  out  1  tile in progress
r_done  out  1  one-cycle tile completion pulse

Behaviour:
- All cache-facing and status outputs registered. Reset (async): FSM IDLE, r_cache_ready=0, r_cache_state=111, addresses=0, r_cache_bus=0, all valids/ready/busy/done=0.
- States: IDLE, CLEAR, LOAD_W, LOAD_A, STREAM, DRAIN, DONE.
- IDLE: r_cache_ready=1 (after first cycle out of reset), state 111. w_start latches all cfg; -> CLEAR if w_cfg_clear else LOAD_W; r_busy=1 from next cycle. Start outside IDLE ignored; cfg changes after start ignored.
- CLEAR: r_cache_ready=0 for exactly one cycle, -> LOAD_W.
- LOAD_W: r_bus_ready=1. Accept = w_bus_valid & r_bus_ready. On accept, next cycle drives state 000, w_addr=count, r_cache_bus=data; count++. No accept -> state 111. After accept with count==nw_m1: count=0, -> LOAD_A (r_bus_ready low the following cycle is not required; it stays high into LOAD_A).
- LOAD_A: same with state 001, a_addr=count, ends at na_m1 -> STREAM; r_bus_ready=0 outside load states.
- STREAM: issue when w_pe_ready: state 100, w_addr=wi, a_addr=ai; wi wraps nw_m1->0, ai wraps na_m1->0, independently, +1 per issue. Beat counter to ns_m1. w_pe_ready low -> state 111, no counter change. r_pe_valid=1 exactly one cycle after each issue (cache read latency 1). Last issue -> DRAIN.
- DRAIN: issue when w_out_ready: state 110, w_addr=pi (zero-extended). r_psum_valid one cycle after issue; downstream must take it (w_out_ready gates issue only). Last issue -> DONE.
- DONE: state 111, r_done=1 one cycle (coincides with final r_psum_valid), r_busy=0 next cycle, -> IDLE.
- Counters never exceed cfg limits; all-ones cfg (256 loads, 65536 beats, 32 psums) legal. m1=0 means one item.
- Reset mid-tile: immediate return to reset values; cache held cleared via r_cache_ready=0 until reset released plus one cycle.

Test Plan:
- Reset then start, clear=1, nw_m1=3, na_m1=1, ns_m1=5, np_m1=1, all valid/ready high -> one ready-low cycle; states 000x4 addr 0..3, 001x2, 100x6 with (w,a)=(0,0),(1,1),(2,0),(3,1),(0,0),(1,1), 110x2 addr 0,1; r_done once.
- Bus valid toggling 1010 during LOAD_W -> state 111 in gap cycles, addresses contiguous, r_cache_bus equals accepted words in order.
- w_pe_ready low for 3 cycles mid-STREAM -> three 111 cycles, no address skip, r_pe_valid count = 6 total.
- nw_m1=255, ns_m1=511 -> w_addr wraps 255->0 at beat 256, final beat w_addr=255.
- w_start pulsed during STREAM with different cfg -> ignored, original sequence completes.
- Assert w_rst during DRAIN -> all outputs at reset values same cycle (async); after release, new start runs cleanly.
